// File: rtl/hex_code_scroller.sv
// Pulse-pattern symbol decoder feeding a scrolling multi-digit 7-seg display.
// Flags invalid codes for a hold time and blanks the display after idle timeout.
module hex_code_scroller #(
  parameter int NUM_DIGITS   = 4,
  parameter int CODE_W       = 8,
  parameter int IDLE_TIMEOUT = 50_000_000,
  parameter int ERR_HOLD     = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [CODE_W-1:0]       code,
  input  logic                    code_valid,
  input  logic                    clear,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic [3:0]              digit_count,
  output logic                    err,
  output logic                    busy
);

  localparam int KRAW = (CODE_W - 1) / 2;
  localparam int KMAX = (KRAW > 15) ? 15 : KRAW;
  localparam int IW   = $clog2(IDLE_TIMEOUT);
  localparam int EW   = $clog2(ERR_HOLD + 1);

  localparam logic [7*NUM_DIGITS-1:0] BLANKS = {NUM_DIGITS{7'h7F}};
  localparam logic [3:0]    CNT_MAX  = 4'(NUM_DIGITS);
  localparam logic [IW-1:0] IDLE_END = IW'(IDLE_TIMEOUT - 1);
  localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_HOLD - 1);

  typedef enum logic {
    EMPTY,
    SHOW
  } state_t;

  state_t                  state_q, state_n;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_n;
  logic [3:0]              cnt_q, cnt_n;
  logic [IW-1:0]           idle_q, idle_n;
  logic [EW-1:0]           errc_q, errc_n;
  logic                    err_q, err_n;

  logic                    dec_ok;
  logic [3:0]              dec_val;

  // Valid shape: 1 followed by k "01" pairs, rest zero; k = symbol value.
  always_comb begin
    logic [CODE_W-1:0] pat;
    dec_ok  = 1'b0;
    dec_val = '0;
    for (int k = 0; k <= KMAX; k++) begin
      pat = '0;
      for (int j = 0; j < CODE_W; j++) begin
        if (j <= 2 * k && (j % 2) == 0) begin
          pat[CODE_W-1-j] = 1'b1;
        end
      end
      if (code == pat) begin
        dec_ok  = 1'b1;
        dec_val = 4'(k);
      end
    end
  end

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    state_n = state_q;
    hex_n   = hex_q;
    cnt_n   = cnt_q;
    idle_n  = idle_q;
    err_n   = err_q;
    errc_n  = errc_q;

    if (err_q) begin
      if (errc_q == '0) begin
        err_n = 1'b0;
      end else begin
        errc_n = errc_q - 1'b1;
      end
    end

    if (clear) begin
      state_n = EMPTY;
      hex_n   = BLANKS;
      cnt_n   = '0;
      idle_n  = '0;
      err_n   = 1'b0;
      errc_n  = '0;
    end else if (code_valid) begin
      idle_n = '0;
      if (dec_ok) begin
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
          hex_n[7*i +: 7] = hex_q[7*(i-1) +: 7];
        end
        hex_n[6:0] = glyph(dec_val);
        cnt_n      = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        state_n    = SHOW;
      end else begin
        err_n  = 1'b1;
        errc_n = ERR_LOAD;
      end
    end else if (state_q == SHOW) begin
      if (idle_q == IDLE_END) begin
        state_n = EMPTY;
        hex_n   = BLANKS;
        cnt_n   = '0;
        idle_n  = '0;
      end else begin
        idle_n = idle_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      hex_q   <= BLANKS;
      cnt_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_n;
      hex_q   <= hex_n;
      cnt_q   <= cnt_n;
      idle_q  <= idle_n;
      err_q   <= err_n;
      errc_q  <= errc_n;
    end
  end

  assign hex_out     = hex_q;
  assign digit_count = cnt_q;
  assign err         = err_q;
  assign busy        = (state_q == SHOW);

endmodule
